alu64_seq: RTL

ALU64_SEQ -- requirements
Module: alu64_seq

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_.sv | 35 +++
 rtl/alu64_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequenced 64-bit ALU: card codes, request opcodes, FSM states.
package alu_pkg;

    localparam logic [4:0] CardAdd2   = 5'b00010;
    localparam logic [4:0] CardAnd    = 5'b01100;
    localparam logic [4:0] CardOr     = 5'b01011;
    localparam logic [4:0] CardSor    = 5'b01101; // XNOR
    localparam logic [4:0] CardNor    = 5'b01110; // XOR
    localparam logic [4:0] CardAndnot = 5'b01111; // NAND

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpAddc = 3'd1,
        OpSub  = 3'd2,
        OpAnd  = 3'd3,
        OpOr   = 3'd4,
        OpXor  = 3'd5,
        OpXnor = 3'd6,
        OpNand = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StDone = 2'd3
    } alu_state_e;

    function automatic logic [4:0] op_card(input alu_op_e op);
        case (op)
            OpAnd:   op_card = CardAnd;
            OpOr:    op_card = CardOr;
            OpXor:   op_card = CardNor;
            OpXnor:  op_card = CardSor;
            OpNand:  op_card = CardAndnot;
            default: op_card = CardAdd2;
        endcase
    endfunction

endpackage

// File: rtl/alu_.sv
// 32-bit combinational ALU slice selected by a 5-bit card code.
module alu_
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    input  logic [4:0]  card_i,
    output logic [31:0] f_o,
    output logic        cout_o,
    output logic        zero_o
);

    logic [32:0] sum;

    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
        f_o    = '0;
        cout_o = 1'b0;
        case (card_i)
            CardAdd2: begin
                f_o    = sum[31:0];
                cout_o = sum[32];
            end
            CardAnd:    f_o = a_i & b_i;
            CardOr:     f_o = a_i | b_i;
            CardSor:    f_o = ~(a_i ^ b_i);
            CardNor:    f_o = a_i ^ b_i;
            CardAndnot: f_o = ~(a_i & b_i);
            default:    f_o = '0;
        endcase
        zero_o = (f_o == 32'd0);
    end

endmodule

// File: rtl/alu64_seq.sv
// 64-bit ALU built from one 32-bit slice used twice: low word pass, then high word pass.
module alu64_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic        req_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_f,
    output logic        rsp_cout,
    output logic        rsp_zero
);

    alu_state_e  state_q, state_d;
    alu_op_e     op_q, op_d;
    logic [63:0] a_q, a_d, b_q, b_d;
    logic        cin_q, cin_d;
    logic [31:0] f_lo_q, f_lo_d;
    logic        cout_lo_q, cout_lo_d, zero_lo_q, zero_lo_d;
    logic [63:0] f_q, f_d;
    logic        cout_q, cout_d, zero_q, zero_d;

    logic        is_arith, hi_pass;
    logic [31:0] a_word, b_word, alu_b, alu_f;
    logic        alu_cin, alu_cout, alu_zero;
    logic [4:0]  alu_card;

    // Operand muxing and carry chaining for the shared slice.
    always_comb begin
        is_arith = (op_q == OpAdd) || (op_q == OpAddc) || (op_q == OpSub);
        hi_pass  = (state_q == StHi);
        alu_card = op_card(op_q);
        a_word   = hi_pass ? a_q[63:32] : a_q[31:0];
        b_word   = hi_pass ? b_q[63:32] : b_q[31:0];
        alu_b    = (op_q == OpSub) ? ~b_word : b_word;
        if (hi_pass) begin
            alu_cin = is_arith & cout_lo_q;
        end else begin
            alu_cin = (op_q == OpSub) || ((op_q == OpAddc) && cin_q);
        end
    end

    alu_ u_alu (
        .a_i    (a_word),
        .b_i    (alu_b),
        .cin_i  (alu_cin),
        .card_i (alu_card),
        .f_o    (alu_f),
        .cout_o (alu_cout),
        .zero_o (alu_zero)
    );

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_f     = f_q;
    assign rsp_cout  = cout_q;
    assign rsp_zero  = zero_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        f_lo_d    = f_lo_q;
        cout_lo_d = cout_lo_q;
        zero_lo_d = zero_lo_q;
        f_d       = f_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    op_d    = alu_op_e'(req_op);
                    a_d     = req_a;
                    b_d     = req_b;
                    cin_d   = req_cin;
                    state_d = StLo;
                end
            end
            StLo: begin
                f_lo_d    = alu_f;
                cout_lo_d = alu_cout;
                zero_lo_d = alu_zero;
                state_d   = StHi;
            end
            StHi: begin
                f_d     = {alu_f, f_lo_q};
                cout_d  = alu_cout;
                zero_d  = zero_lo_q & alu_zero;
                state_d = StDone;
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= OpAdd;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            f_lo_q    <= '0;
            cout_lo_q <= 1'b0;
            zero_lo_q <= 1'b0;
            f_q       <= '0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            f_lo_q    <= f_lo_d;
            cout_lo_q <= cout_lo_d;
            zero_lo_q <= zero_lo_d;
            f_q       <= f_d;
            cout_q    <= cout_d;
            zero_q    <= zero_d;
        end
    end

endmodule
